// File: rtl/serial_parity_rx_pkg.sv
// Shared types and helpers for the serial parity receiver.
package serial_parity_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Error flag for a completed frame: acc is the XOR of data and parity bits.
  function automatic logic parity_error(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/serial_parity_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// Serial receiver: start, LSB-first data, parity, stop; word presented on valid/ready.
// Handshake: a word transfers on any rising edge where data_valid & data_ready; data_valid holds until then.
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ODD_PARITY   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun,
  output logic [2:0]            state_dbg
);

  localparam int BW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic ODD = 1'(ODD_PARITY);

  rx_state_t state, state_next;
  logic rx_s, rx_prev;
  logic [BW-1:0]  baud_cnt;
  logic [BCW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH:0]   shift_cat;
  logic acc;
  logic clr, do_data, do_par, do_stop;
  logic baud_done, half_done;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign baud_done = (baud_cnt == BAUD_MAX);
  assign half_done = (baud_cnt == BAUD_HALF);
  assign shift_cat = {rx_s, shift_reg};
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    clr        = 1'b0;
    do_data    = 1'b0;
    do_par     = 1'b0;
    do_stop    = 1'b0;
    unique case (state)
      IDLE: if (rx_prev && !rx_s) begin
        state_next = START;
        clr        = 1'b1;
      end
      // Mid-start check rejects glitches shorter than half a bit.
      START: if (half_done) begin
        clr        = 1'b1;
        state_next = rx_s ? IDLE : DATA;
      end
      DATA: if (baud_done) begin
        do_data = 1'b1;
        if (bit_cnt == BIT_LAST) state_next = PARITY;
      end
      PARITY: if (baud_done) begin
        do_par     = 1'b1;
        state_next = STOP;
      end
      STOP: if (baud_done) begin
        do_stop    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_prev   <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      acc       <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      if (state == IDLE || clr || do_data || do_par || do_stop) baud_cnt <= '0;
      else                                                       baud_cnt <= baud_cnt + 1'b1;
      if (clr) begin
        bit_cnt <= '0;
        acc     <= 1'b0;
      end else if (do_data) begin
        bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        shift_reg <= shift_cat[DATA_WIDTH:1];
        acc       <= acc ^ rx_s;
      end else if (do_par) begin
        acc <= acc ^ rx_s;
      end
    end
  end

  // A completed frame is only loaded if the output slot is free or draining this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (do_stop) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_reg;
          parity_err <= parity_error(acc, ODD);
          frame_err  <= ~rx_s;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed and random frames against a frame-level reference model of the receiver.
module tb_serial_parity_rx;

  localparam int W   = 8;
  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         rx = 1'b1;
  logic [W-1:0] data_out;
  logic         parity_err, frame_err, data_valid, overrun;
  logic         data_ready = 1'b1;
  logic [2:0]   state_dbg;

  int compared = 0;
  int mismatched = 0;
  int ovr_cnt = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];

  serial_parity_rx #(.DATA_WIDTH(W), .CLKS_PER_BIT(CPB), .ODD_PARITY(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .data_out   (data_out),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // Record every accepted word and every overrun pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n && data_valid && data_ready) got_q.push_back({frame_err, parity_err, data_out});
    if (reset_n && overrun) ovr_cnt++;
  end

  // Frame-level model: even parity over data and parity bit; stop bit 0 means framing error.
  function automatic logic [W+1:0] model(input logic [W-1:0] d, input logic par, input logic stop);
    logic pe;
    pe = (^d) ^ par;
    return {~stop, pe, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < W; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input string tag);
    logic [W+1:0] got, exp;
    int waited;
    waited = 0;
    while (got_q.size() == 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (got_q.size() == 0) begin
      check({tag, "_timeout"}, 32'(got_q.size()), 32'd1);
      void'(exp_q.pop_front());
    end else begin
      got = got_q.pop_front();
      exp = exp_q.pop_front();
      check(tag, 32'(got), 32'(exp));
    end
  endtask

  initial begin
    logic [W-1:0] d;
    logic par, stop;
    int ovr_base;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_flags", 32'({parity_err, frame_err, overrun}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);

    // 1: clean frame
    exp_q.push_back(model(8'hA5, 1'b0, 1'b1));
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    expect_frame("t1_a5");
    check("t1_valid_dropped", 32'(data_valid), 32'd0);

    // 2: parity error
    exp_q.push_back(model(8'h07, 1'b0, 1'b1));
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    expect_frame("t2_parity");

    // 3: framing error then break
    exp_q.push_back(model(8'h3C, 1'b0, 1'b0));
    send_frame(8'h3C, 1'b0, 1'b0);
    expect_frame("t3_frame");
    rx = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("t3_break_silent", 32'(got_q.size()), 32'd0);
    idle(20);

    // 4: short glitch rejected, then a good frame
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    check("t4_glitch_none", 32'(got_q.size()), 32'd0);
    check("t4_state_idle", 32'(state_dbg), 32'd0);
    exp_q.push_back(model(8'h55, 1'b0, 1'b1));
    send_frame(8'h55, 1'b0, 1'b1);
    idle(4);
    expect_frame("t4_55");

    // 5: backpressure and overrun
    data_ready = 1'b0;
    ovr_base = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    idle(4);
    send_frame(8'h22, 1'b0, 1'b1);
    idle(20);
    check("t5_valid_held", 32'(data_valid), 32'd1);
    check("t5_data_held", 32'(data_out), 32'h11);
    check("t5_overrun_once", 32'(ovr_cnt - ovr_base), 32'd1);
    exp_q.push_back(model(8'h11, 1'b0, 1'b1));
    @(posedge clk);
    #1;
    data_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t5_valid_cleared", 32'(data_valid), 32'd0);
    check("t5_data_kept", 32'(data_out), 32'h11);
    expect_frame("t5_11");
    idle(10);

    // 6: reset mid-frame
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_data", 32'(data_out), 32'd0);
    check("t6_async_valid", 32'(data_valid), 32'd0);
    check("t6_async_state", 32'(state_dbg), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle(40);
    check("t6_no_partial", 32'(got_q.size()), 32'd0);
    exp_q.push_back(model(8'h81, 1'b0, 1'b1));
    send_frame(8'h81, 1'b0, 1'b1);
    idle(4);
    expect_frame("t6_81");

    // Random frames with random parity and stop bits
    for (int i = 0; i < 10; i++) begin
      d    = W'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(d, par, stop));
      send_frame(d, par, stop);
      expect_frame("rand_frame");
      idle($urandom_range(1, 20));
    end
    check("end_overrun_total", 32'(ovr_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
